// File: rtl/ad9361_rx_if_pkg.sv
// Shared types and constants for the AD9361 RX-interface frame generator.
package ad9361_rx_if_pkg;

   localparam int SAMPLE_W   = 12;
   localparam int WORDS_1R1T = 4;
   localparam int WORDS_2R2T = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   typedef struct packed {
      logic [SAMPLE_W-1:0] i0;
      logic [SAMPLE_W-1:0] q0;
      logic [SAMPLE_W-1:0] i1;
      logic [SAMPLE_W-1:0] q1;
   } samples_t;

endpackage

// File: rtl/ad9361_rx_word_mux.sv
// Picks the 6-bit interface word for word index w from a latched sample set.
module ad9361_rx_word_mux
   import ad9361_rx_if_pkg::*;
(
   input  samples_t     samples,
   input  logic [2:0]   w,
   input  logic         r1_mode,
   output logic [5:0]   word
);

   logic [SAMPLE_W-1:0] sel;
   logic                lsb_half;

   // 1R1T: w[0] picks I/Q, w[1] picks the half. 2R2T: w[1:0] picks the channel, w[2] the half.
   always_comb begin
      sel      = samples.i0;
      lsb_half = 1'b0;
      if (r1_mode) begin
         lsb_half = w[1];
         sel      = w[0] ? samples.q0 : samples.i0;
      end else begin
         lsb_half = w[2];
         case (w[1:0])
            2'd0:    sel = samples.i0;
            2'd1:    sel = samples.q0;
            2'd2:    sel = samples.i1;
            default: sel = samples.q1;
         endcase
      end
      word = lsb_half ? sel[5:0] : sel[11:6];
   end

endmodule

// File: rtl/ad9361_rx_if_gen.sv
// Streams I/Q sample sets as back-to-back 6-bit RX-interface frames (1R1T or 2R2T).
module ad9361_rx_if_gen
   import ad9361_rx_if_pkg::*;
#(
   parameter logic [5:0] IDLE_DATA = 6'h00,
   parameter int         CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic                 r1_mode,
   // Sample set moves on s_valid & s_ready; s_valid may rise or fall at any time.
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [11:0]          s_i0,
   input  logic [11:0]          s_q0,
   input  logic [11:0]          s_i1,
   input  logic [11:0]          s_q1,
   output logic                 rx_frame,
   output logic [5:0]           rx_data,
   output logic                 active,
   output logic                 underflow,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [1:0]           state_dbg
);

   state_t     state, state_n;
   logic [2:0] w, w_n, last_w, half_w;
   logic       mode_r, mode_n;
   logic       data_r, data_n;
   logic       uf_n, fc_inc, hs;
   samples_t   samp_r, samp_n, samp_in;
   logic [5:0] word_n;

   assign samp_in   = '{i0: s_i0, q0: s_q0, i1: s_i1, q1: s_q1};
   assign last_w    = mode_r ? 3'(WORDS_1R1T - 1) : 3'(WORDS_2R2T - 1);
   assign s_ready   = enable & ((state == ST_IDLE) | ((state == ST_RUN) & (w == last_w)));
   assign hs        = s_valid & s_ready;
   assign state_dbg = state;

   always_comb begin
      state_n = state;
      w_n     = w;
      mode_n  = mode_r;
      data_n  = data_r;
      samp_n  = samp_r;
      uf_n    = 1'b0;
      fc_inc  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (hs) begin
               state_n = ST_RUN;
               w_n     = 3'd0;
               mode_n  = r1_mode;
               data_n  = 1'b1;
               samp_n  = samp_in;
               fc_inc  = 1'b1;
            end
         end
         ST_RUN: begin
            if (w != last_w) begin
               w_n = w + 3'd1;
            end else if (!enable) begin
               state_n = ST_STOP;
               w_n     = 3'd0;
               data_n  = 1'b0;
            end else begin
               // Next frame starts regardless of data so the frame timing never slips.
               w_n    = 3'd0;
               mode_n = r1_mode;
               data_n = hs;
               fc_inc = hs;
               uf_n   = ~hs;
               if (hs) samp_n = samp_in;
            end
         end
         ST_STOP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   assign half_w = mode_n ? 3'(WORDS_1R1T / 2) : 3'(WORDS_2R2T / 2);

   ad9361_rx_word_mux u_word_mux (
      .samples (samp_n),
      .w       (w_n),
      .r1_mode (mode_n),
      .word    (word_n)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         w           <= 3'd0;
         mode_r      <= 1'b1;
         data_r      <= 1'b0;
         samp_r      <= '0;
         rx_frame    <= 1'b0;
         rx_data     <= IDLE_DATA;
         active      <= 1'b0;
         underflow   <= 1'b0;
         frame_count <= '0;
      end else begin
         state     <= state_n;
         w         <= w_n;
         mode_r    <= mode_n;
         data_r    <= data_n;
         samp_r    <= samp_n;
         rx_frame  <= (state_n == ST_RUN) && (w_n < half_w);
         rx_data   <= ((state_n == ST_RUN) && data_n) ? word_n : IDLE_DATA;
         active    <= (state_n == ST_RUN);
         underflow <= uf_n;
         if (fc_inc) frame_count <= frame_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_ad9361_rx_if_gen.sv
// Directed bench for ad9361_rx_if_gen: word order, underflow, stop, async reset, count wrap.
module tb_ad9361_rx_if_gen;

   localparam logic [5:0] IDLE = 6'h2D;

   logic        clk = 1'b0;
   logic        resetn, enable, r1_mode, s_valid, s_ready;
   logic [11:0] s_i0, s_q0, s_i1, s_q1;
   logic        rx_frame, active, underflow;
   logic [5:0]  rx_data;
   logic [3:0]  frame_count;
   logic [1:0]  state_dbg;

   int         checks   = 0;
   int         failures = 0;
   logic [5:0] exp_q[$];

   always #5 clk = ~clk;

   ad9361_rx_if_gen #(.IDLE_DATA(IDLE), .CNT_WIDTH(4)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .enable      (enable),
      .r1_mode     (r1_mode),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_i0        (s_i0),
      .s_q0        (s_q0),
      .s_i1        (s_i1),
      .s_q1        (s_q1),
      .rx_frame    (rx_frame),
      .rx_data     (rx_data),
      .active      (active),
      .underflow   (underflow),
      .frame_count (frame_count),
      .state_dbg   (state_dbg)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_r1_abc();
      exp_q.push_back(6'h2A); exp_q.push_back(6'h04);
      exp_q.push_back(6'h3C); exp_q.push_back(6'h23);
   endtask

   task automatic push_r2();
      exp_q.push_back(6'h00); exp_q.push_back(6'h3F);
      exp_q.push_back(6'h20); exp_q.push_back(6'h1F);
      exp_q.push_back(6'h01); exp_q.push_back(6'h3F);
      exp_q.push_back(6'h00); exp_q.push_back(6'h3F);
   endtask

   task automatic frame_part(input string tag, input int nw, input int w_lo, input int w_hi,
                             input logic eu, input logic [3:0] efc);
      logic [5:0] d;
      for (int w = w_lo; w <= w_hi; w++) begin
         tick();
         d = (exp_q.size() > 0) ? exp_q.pop_front() : 6'bx;
         chk($sformatf("%s_w%0d_data", tag, w), rx_data, d);
         chk($sformatf("%s_w%0d_frame", tag, w), rx_frame, w < nw / 2);
         chk($sformatf("%s_w%0d_active", tag, w), active, 1'b1);
         chk($sformatf("%s_w%0d_uf", tag, w), underflow, (w == 0) ? eu : 1'b0);
         chk($sformatf("%s_w%0d_fc", tag, w), frame_count, efc);
         chk($sformatf("%s_w%0d_ready", tag, w), s_ready, (w == nw - 1) && enable);
      end
   endtask

   task automatic idle_chk(input string tag, input logic [3:0] efc, input logic erdy);
      chk({tag, "_frame"}, rx_frame, 1'b0);
      chk({tag, "_data"}, rx_data, IDLE);
      chk({tag, "_active"}, active, 1'b0);
      chk({tag, "_uf"}, underflow, 1'b0);
      chk({tag, "_fc"}, frame_count, efc);
      chk({tag, "_ready"}, s_ready, erdy);
   endtask

   initial begin
      resetn = 1'b0; enable = 1'b0; r1_mode = 1'b1; s_valid = 1'b0;
      s_i0 = '0; s_q0 = '0; s_i1 = '0; s_q1 = '0;
      repeat (2) tick();
      idle_chk("reset", 4'd0, 1'b0);

      resetn = 1'b1; s_i0 = 12'hABC; s_q0 = 12'h123; s_valid = 1'b1; enable = 1'b1;
      #1;
      idle_chk("idle_ready", 4'd0, 1'b1);

      // 1R1T stream; samples disturbed mid-frame must not leak into the frame in flight
      push_r1_abc(); frame_part("r1_f1", 4, 0, 3, 1'b0, 4'd1);
      push_r1_abc(); frame_part("r1_f2", 4, 0, 0, 1'b0, 4'd2);
      s_i0 = 12'h000; s_q0 = 12'h000;
      frame_part("r1_f2", 4, 1, 2, 1'b0, 4'd2);
      s_i0 = 12'hABC; s_q0 = 12'h123;
      frame_part("r1_f2", 4, 3, 3, 1'b0, 4'd2);

      // valid drops for one frame: filler frame with underflow, count frozen
      push_r1_abc(); frame_part("r1_f3", 4, 0, 0, 1'b0, 4'd3);
      s_valid = 1'b0;
      frame_part("r1_f3", 4, 1, 3, 1'b0, 4'd3);
      repeat (4) exp_q.push_back(IDLE);
      frame_part("uf", 4, 0, 0, 1'b1, 4'd3);
      s_valid = 1'b1;
      frame_part("uf", 4, 1, 3, 1'b0, 4'd3);
      push_r1_abc(); frame_part("r1_f4", 4, 0, 3, 1'b0, 4'd4);

      // mode flips mid-frame; current frame keeps 4 words, next is 2R2T
      push_r1_abc(); frame_part("modechg", 4, 0, 0, 1'b0, 4'd5);
      r1_mode = 1'b0; s_i0 = 12'h001; s_q0 = 12'hFFF; s_i1 = 12'h800; s_q1 = 12'h7FF;
      frame_part("modechg", 4, 1, 3, 1'b0, 4'd5);
      push_r2(); frame_part("r2_f1", 8, 0, 7, 1'b0, 4'd6);

      // enable dropped at w=1: frame completes, one STOP cycle, then quiet IDLE
      push_r2(); frame_part("r2_f2", 8, 0, 1, 1'b0, 4'd7);
      enable = 1'b0;
      frame_part("r2_f2", 8, 2, 7, 1'b0, 4'd7);
      tick(); idle_chk("stop", 4'd7, 1'b0);
      tick(); idle_chk("idle", 4'd7, 1'b0);
      repeat (3) begin
         tick(); idle_chk("idle_hold", 4'd7, 1'b0);
      end

      // asynchronous reset at w=2, then restart from w=0
      r1_mode = 1'b1; s_i0 = 12'hABC; s_q0 = 12'h123; enable = 1'b1;
      #1;
      idle_chk("rearm", 4'd7, 1'b1);
      push_r1_abc(); frame_part("rst_f", 4, 0, 2, 1'b0, 4'd8);
      resetn = 1'b0;
      #1;
      idle_chk("async_rst", 4'd0, 1'b1);
      exp_q.delete();
      #1;
      resetn = 1'b1;

      // 17 data frames with a 4-bit counter wrap back to 1
      for (int f = 1; f <= 17; f++) begin
         push_r1_abc();
         frame_part($sformatf("wrap%0d", f), 4, 0, 3, 1'b0, 4'(f));
      end
      chk("wrap_final", frame_count, 4'd1);

      enable = 1'b0;
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
